// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, the CALL
// opcode seen by the control-unit decode table, and the injected word layout.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INJECT  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam logic [4:0] CALL_OPCODE = 5'b10110;

    localparam int CALL_W  = 29;
    localparam int OPC_MSB = 28;
    localparam int OPC_LSB = 24;
    localparam int RSV_MSB = 23;
    localparam int RSV_LSB = 16;
    localparam int TGT_MSB = 15;
    localparam int TGT_LSB = 0;
    localparam int TGT_W   = TGT_MSB - TGT_LSB + 1;

    function automatic logic [CALL_W-1:0] build_call(input logic [TGT_W-1:0] target);
        logic [CALL_W-1:0] w;
        w                  = '0;
        w[OPC_MSB:OPC_LSB] = CALL_OPCODE;
        w[RSV_MSB:RSV_LSB] = '0;
        w[TGT_MSB:TGT_LSB] = target;
        return w;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: valid plus index of the lowest set bit.
module int_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronised edge/level capture, pending latch,
// fixed-priority arbitration with optional nesting, CALL injection at fetch.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_IRQ     = 8,
    parameter int ADDR_W    = 16,
    parameter int INST_W    = 29,
    parameter int VEC_SHIFT = 2
) (
    input  logic                     clk_bus,
    input  logic                     rst_bus,
    input  logic [N_IRQ-1:0]         irq_in,
    input  logic [N_IRQ-1:0]         cfg_en,
    input  logic [N_IRQ-1:0]         cfg_edge,
    input  logic                     nest_en,
    input  logic [ADDR_W-1:0]        vec_base,
    input  logic                     inst_boundary,
    input  logic                     eoi,
    output logic                     inject,
    output logic [INST_W-1:0]        inject_inst,
    output logic [$clog2(N_IRQ)-1:0] active_id,
    output logic [N_IRQ-1:0]         pending,
    output logic [N_IRQ-1:0]         in_service,
    output logic                     eoi_err
);

    localparam int ID_W = $clog2(N_IRQ);

    state_e                   state_q, state_d;
    logic [1:0][N_IRQ-1:0]    sync_q, sync_d;
    logic [N_IRQ-1:0]         prev_q, prev_d;
    logic [N_IRQ-1:0]         pending_q, pending_d;
    logic [N_IRQ-1:0]         in_service_q, in_service_d;
    logic                     eoi_err_q, eoi_err_d;
    logic                     inject_q, inject_d;
    logic [INST_W-1:0]        inst_q, inst_d;
    logic [ID_W-1:0]          active_id_q, active_id_d;

    logic [N_IRQ-1:0]         irq_s, rise, set_vec, blocked, eligible;
    logic [N_IRQ-1:0]         grant_clr, eoi_clr;
    logic                     grant_vld, eoi_vld, take, run;
    logic [ID_W-1:0]          grant_idx, eoi_idx;
    logic [ADDR_W-1:0]        target;
    logic [CALL_W-1:0]        call_word;

    int_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_grant_enc (
        .req   (eligible),
        .valid (grant_vld),
        .idx   (grant_idx)
    );

    int_prio_enc #(.N(N_IRQ), .IDX_W(ID_W)) u_eoi_enc (
        .req   (in_service_q),
        .valid (eoi_vld),
        .idx   (eoi_idx)
    );

    always_comb begin
        sync_d  = {sync_q[0], irq_in};
        prev_d  = sync_q[1];
        irq_s   = sync_q[1];
        rise    = irq_s & ~prev_q;
        set_vec = cfg_en & ((cfg_edge & rise) | (~cfg_edge & irq_s));

        // With nesting, a channel is blocked by any in-service channel of equal or higher priority.
        run     = 1'b0;
        blocked = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            run        = run | in_service_q[i];
            blocked[i] = nest_en ? run : (|in_service_q);
        end
        eligible = pending_q & cfg_en & ~blocked;

        target    = vec_base + (ADDR_W'(grant_idx) << VEC_SHIFT);
        call_word = build_call(TGT_W'(target));
    end

    always_comb begin
        state_d     = state_q;
        inject_d    = 1'b0;
        inst_d      = '0;
        active_id_d = active_id_q;
        take        = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld && inst_boundary) begin
                    take        = 1'b1;
                    state_d     = INJECT;
                    inject_d    = 1'b1;
                    inst_d      = INST_W'(call_word);
                    active_id_d = grant_idx;
                end
            end
            INJECT:  state_d = HOLDOFF;
            HOLDOFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // EOI clears from the pre-injection in_service; the new grant is OR'd in afterwards.
    always_comb begin
        grant_clr    = take ? (N_IRQ'(1) << grant_idx) : '0;
        eoi_clr      = (eoi && eoi_vld) ? (N_IRQ'(1) << eoi_idx) : '0;
        pending_d    = (pending_q & ~grant_clr) | set_vec;
        in_service_d = (in_service_q & ~eoi_clr) | grant_clr;
        eoi_err_d    = eoi_err_q | (eoi & ~eoi_vld);
    end

    always_ff @(posedge clk_bus or negedge rst_bus) begin
        if (!rst_bus) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            eoi_err_q    <= 1'b0;
            inject_q     <= 1'b0;
            inst_q       <= '0;
            active_id_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            eoi_err_q    <= eoi_err_d;
            inject_q     <= inject_d;
            inst_q       <= inst_d;
            active_id_q  <= active_id_d;
        end
    end

    assign inject      = inject_q;
    assign inject_inst = inst_q;
    assign active_id   = active_id_q;
    assign pending     = pending_q;
    assign in_service  = in_service_q;
    assign eoi_err     = eoi_err_q;

endmodule
